cnn_frame_feeder: RTL and testbench

Host-side driver for the `cnn_top` core interface. It accepts a pixel stream over a valid/ready handshake and buffers one full frame. It then issues a single-cycle `enable` to the core, waits for the core's `done`, and returns the core's `value` over a valid/ready result handshake. It sits between the system interconnect and `cnn_top`, taking over the role the bench plays when it drives the core directly.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/cnn_img_buffer.sv | 46 ++++
 rtl/cnn_frame_feeder.sv | 162 ++++++++++++++++
 tb/tb_cnn_frame_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN host-side frame feeder and the cnn_top core.
//   feeder_state_t : control states of cnn_frame_feeder
//   CNN_*          : default frame geometry and result width used by both sides
package cnn_pkg;

  localparam int CNN_IMG_SIZE = 64;  // pixels per frame
  localparam int CNN_DATA_W   = 32;  // pixel width
  localparam int CNN_OUT_W    = 32;  // core result width

  typedef enum logic [1:0] {
    LOAD   = 2'd0,  // accepting pixels into the frame buffer
    START  = 2'd1,  // one-cycle enable pulse to the core
    WAIT   = 2'd2,  // waiting for a core_done rising edge or timeout
    RESULT = 2'd3   // presenting the result until it is taken
  } feeder_state_t;

endpackage

// File: rtl/cnn_img_buffer.sv
// Frame buffer: DEPTH x DATA_W register file, one synchronous write port,
// the whole contents presented as a flat vector.
//   clk, rst : clock, synchronous active-high reset (clears every word)
//   we       : write enable
//   waddr    : word address
//   wdata    : word to write
//   flat     : word i at flat[i*DATA_W +: DATA_W]
module cnn_img_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH  = CNN_IMG_SIZE,
  parameter int DATA_W = CNN_DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DEPTH*DATA_W-1:0] flat
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: this storage is reset on purpose -- the frame seen by the core
  // after reset must read as all zeros -- so it maps to resettable flops,
  // not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign flat[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule

// File: rtl/cnn_frame_feeder.sv
// Host-side driver for the cnn_top core. Buffers one frame from a
// valid/ready pixel stream, pulses core_enable, waits for a core_done
// rising edge (or a timeout) and returns the result over valid/ready.
//   clk, rst              : clock, synchronous active-high reset
//   s_valid/s_data/s_ready: pixel stream in
//   img_flat              : buffered frame to the core
//   core_enable           : one-cycle start pulse
//   core_value/core_done  : core result and completion (level or pulse)
//   r_valid/r_data/r_err  : result out (r_err = timeout, r_data = 0)
//   r_ready               : downstream accepts the result
//   busy                  : high whenever not loading pixels
module cnn_frame_feeder
  import cnn_pkg::*;
#(
  parameter int IMG_SIZE = CNN_IMG_SIZE,
  parameter int DATA_W   = CNN_DATA_W,
  parameter int OUT_W    = CNN_OUT_W,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       s_ready,
  output logic [IMG_SIZE*DATA_W-1:0] img_flat,
  output logic                       core_enable,
  input  logic [OUT_W-1:0]           core_value,
  input  logic                       core_done,
  output logic                       r_valid,
  output logic [OUT_W-1:0]           r_data,
  output logic                       r_err,
  input  logic                       r_ready,
  output logic                       busy
);

  localparam int CNT_W = $clog2(IMG_SIZE);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_SIZE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             done_q, done_d;
  logic             core_enable_q, core_enable_d;
  logic             r_valid_q, r_valid_d;
  logic [OUT_W-1:0] r_data_q, r_data_d;
  logic             r_err_q, r_err_d;
  logic             accept;
  logic             buf_we;

  // Decoded, not registered: the stream stalls during reset.
  assign s_ready = (state_q == LOAD) && !rst;
  assign busy    = (state_q != LOAD);
  assign accept  = s_valid && s_ready;

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    done_d        = core_done;  // tracked every cycle; only WAIT looks for an edge
    core_enable_d = 1'b0;
    r_valid_d     = r_valid_q;
    r_data_d      = r_data_q;
    r_err_d       = r_err_q;
    buf_we        = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          buf_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d         = '0;
            tmo_d         = '0;
            core_enable_d = 1'b1;
            state_d       = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      START: begin
        // The timeout counter runs from the enable cycle, so r_valid with
        // r_err appears exactly TIMEOUT cycles after core_enable.
        if (tmo_q != TMO_LAST) tmo_d = tmo_q + 1'b1;
        state_d = WAIT;
      end

      WAIT: begin
        // An edge beats expiry in the same cycle.
        if (core_done && !done_q) begin
          r_data_d  = core_value;
          r_err_d   = 1'b0;
          r_valid_d = 1'b1;
          state_d   = RESULT;
        end else if (tmo_q == TMO_LAST) begin
          r_data_d  = '0;
          r_err_d   = 1'b1;
          r_valid_d = 1'b1;
          state_d   = RESULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RESULT: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          state_d   = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      cnt_q         <= '0;
      tmo_q         <= '0;
      done_q        <= 1'b0;
      core_enable_q <= 1'b0;
      r_valid_q     <= 1'b0;
      r_data_q      <= '0;
      r_err_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      done_q        <= done_d;
      core_enable_q <= core_enable_d;
      r_valid_q     <= r_valid_d;
      r_data_q      <= r_data_d;
      r_err_q       <= r_err_d;
    end
  end

  cnn_img_buffer #(
    .DEPTH  (IMG_SIZE),
    .DATA_W (DATA_W),
    .AW     (CNT_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (cnt_q),
    .wdata (s_data),
    .flat  (img_flat)
  );

  assign core_enable = core_enable_q;
  assign r_valid     = r_valid_q;
  assign r_data      = r_data_q;
  assign r_err       = r_err_q;

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Directed bench for cnn_frame_feeder (IMG_SIZE 64, TIMEOUT 16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cnn_frame_feeder;

  localparam int IMG  = 64;
  localparam int DW   = 32;
  localparam int OW   = 32;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [DW-1:0]     s_data;
  logic              s_ready;
  logic [IMG*DW-1:0] img_flat;
  logic              core_enable;
  logic [OW-1:0]     core_value;
  logic              core_done;
  logic              r_valid;
  logic [OW-1:0]     r_data;
  logic              r_err;
  logic              r_ready;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  int en_count = 0;
  int en_base;

  always #5 clk = ~clk;

  // Counts enable pulses, sampled at the rising edge that ends each cycle.
  always @(posedge clk) if (core_enable) en_count++;

  cnn_frame_feeder #(
    .IMG_SIZE (IMG),
    .DATA_W   (DW),
    .OUT_W    (OW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .img_flat    (img_flat),
    .core_enable (core_enable),
    .core_value  (core_value),
    .core_done   (core_done),
    .r_valid     (r_valid),
    .r_data      (r_data),
    .r_err       (r_err),
    .r_ready     (r_ready),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return img_flat[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] pix(input int kind, input int i);
    case (kind)
      0:       return 32'd1;
      1:       return 32'(i);
      2:       return 32'(i + 100);
      3:       return 32'(i * 2);
      default: return 32'h77;
    endcase
  endfunction

  // One pixel per cycle (plus optional idle cycles); ends on the falling
  // edge after the last accept with s_valid low.
  task automatic send_pixels(input int n, input int kind, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = pix(kind, i);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; core_value = '0;
    core_done = 1'b0; r_ready = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_s_ready",  64'(s_ready), 64'(0));
    check("rst_busy",     64'(busy), 64'(0));
    check("rst_enable",   64'(core_enable), 64'(0));
    check("rst_r_valid",  64'(r_valid), 64'(0));
    check("rst_r_err",    64'(r_err), 64'(0));
    check("rst_r_data",   64'(r_data), 64'(0));
    check("rst_flat",     64'(|img_flat), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rel_s_ready",  64'(s_ready), 64'(1));

    // ---- basic frame: 64 ones, done rises 10 cycles after enable ----
    en_base = en_count;
    send_pixels(IMG, 0, 1'b0);
    check("b_enable",     64'(core_enable), 64'(1));
    check("b_en_before",  64'(en_count - en_base), 64'(0));
    check("b_busy",       64'(busy), 64'(1));
    check("b_s_ready",    64'(s_ready), 64'(0));
    core_value = 32'd64;
    @(negedge clk);
    check("b_enable_off", 64'(core_enable), 64'(0));
    repeat (9) @(negedge clk);
    check("b_rv_early",   64'(r_valid), 64'(0));
    core_done = 1'b1;
    @(negedge clk);
    check("b_r_valid",    64'(r_valid), 64'(1));
    check("b_r_data",     64'(r_data), 64'(64));
    check("b_r_err",      64'(r_err), 64'(0));
    check("b_en_count",   64'(en_count - en_base), 64'(1));
    core_done = 1'b0;
    r_ready   = 1'b1;
    @(negedge clk);
    check("b_rv_clear",   64'(r_valid), 64'(0));
    check("b_s_ready_k1", 64'(s_ready), 64'(1));
    check("b_busy_off",   64'(busy), 64'(0));
    r_ready = 1'b0;

    // ---- ordering under bubbles: pixel i = i ----
    en_base = en_count;
    send_pixels(IMG, 1, 1'b1);
    check("o_enable",     64'(core_enable), 64'(1));
    check("o_en_before",  64'(en_count - en_base), 64'(0));
    for (int i = 0; i < IMG; i++) check($sformatf("o_word%0d", i), 64'(word(i)), 64'(i));
    core_value = 32'hA5A5_0001;
    repeat (3) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    check("o_r_valid",    64'(r_valid), 64'(1));
    check("o_r_data",     64'(r_data), 64'(32'hA5A5_0001));
    check("o_en_count",   64'(en_count - en_base), 64'(1));

    // ---- result backpressure with the next frame's pixel waiting ----
    core_done = 1'b0;
    core_value = 32'h0BAD_0BAD;
    s_valid = 1'b1;
    s_data  = 32'h77;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_r_valid", 64'(r_valid), 64'(1));
      check("bp_r_data",  64'(r_data), 64'(32'hA5A5_0001));
      check("bp_s_ready", 64'(s_ready), 64'(0));
      check("bp_word0",   64'(word(0)), 64'(0));
      check("bp_word63",  64'(word(63)), 64'(63));
    end
    r_ready = 1'b1;
    @(negedge clk);
    check("bp_rv_clear",  64'(r_valid), 64'(0));
    check("bp_s_ready",   64'(s_ready), 64'(1));
    check("bp_word0_old", 64'(word(0)), 64'(0));
    r_ready = 1'b0;
    @(negedge clk);
    check("bp_first_pix", 64'(word(0)), 64'(32'h77));

    // ---- reset after 30 pixels ----
    send_pixels(29, 4, 1'b0);
    check("m_word29",     64'(word(29)), 64'(32'h77));
    rst = 1'b1;
    @(negedge clk);
    check("m_s_ready",    64'(s_ready), 64'(0));
    check("m_busy",       64'(busy), 64'(0));
    check("m_enable",     64'(core_enable), 64'(0));
    check("m_r_valid",    64'(r_valid), 64'(0));
    check("m_r_err",      64'(r_err), 64'(0));
    check("m_r_data",     64'(r_data), 64'(0));
    check("m_flat",       64'(|img_flat), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("m_s_ready_up", 64'(s_ready), 64'(1));

    // ---- full frame after reset, with core_done held high across START ----
    en_base    = en_count;
    core_done  = 1'b1;
    core_value = 32'hDEAD;
    send_pixels(IMG, 2, 1'b0);
    check("s_enable",     64'(core_enable), 64'(1));
    check("s_word0",      64'(word(0)), 64'(100));
    check("s_word63",     64'(word(63)), 64'(163));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("s_stale_hi", 64'(r_valid), 64'(0));
    end
    core_done = 1'b0;
    @(negedge clk);
    check("s_stale_lo",   64'(r_valid), 64'(0));
    core_done  = 1'b1;
    core_value = 32'h1234;
    @(negedge clk);
    check("s_r_valid",    64'(r_valid), 64'(1));
    check("s_r_data",     64'(r_data), 64'(32'h1234));
    check("s_r_err",      64'(r_err), 64'(0));
    core_value = 32'hBEEF;
    core_done  = 1'b0;
    @(negedge clk);
    check("s_r_hold",     64'(r_data), 64'(32'h1234));
    check("s_en_count",   64'(en_count - en_base), 64'(1));
    r_ready = 1'b1;
    @(negedge clk);
    check("s_rv_clear",   64'(r_valid), 64'(0));
    r_ready = 1'b0;

    // ---- timeout: core_done never rises ----
    send_pixels(IMG, 3, 1'b0);
    check("t_enable",     64'(core_enable), 64'(1));
    check("t_word63",     64'(word(63)), 64'(126));
    for (int c = 1; c < TMO; c++) begin
      @(negedge clk);
      check($sformatf("t_wait%0d", c), 64'(r_valid), 64'(0));
    end
    @(negedge clk);
    check("t_r_valid",    64'(r_valid), 64'(1));
    check("t_r_err",      64'(r_err), 64'(1));
    check("t_r_data",     64'(r_data), 64'(0));
    check("t_busy",       64'(busy), 64'(1));
    r_ready = 1'b1;
    @(negedge clk);
    check("t_rv_clear",   64'(r_valid), 64'(0));
    check("t_s_ready",    64'(s_ready), 64'(1));
    r_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
